// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-2 result steering stage.
// Optional build macro used by this slice: DEMUX_FLUSH_EN.
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_DEPTH = 2;
    localparam int DEMUX_PTR_W = $clog2(DEMUX_DEPTH);

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small per-output FIFO with power-of-two depth and naturally wrapping pointers.
// DEMUX_FLUSH_EN adds a synchronous flush input that empties the FIFO.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
`ifdef DEMUX_FLUSH_EN
    input  logic             flush,
`endif
    output logic             not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;
    logic             flush_s;

`ifdef DEMUX_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != {CNT_W{1'b0}});
    assign head_data = mem_q[rd_ptr_q];

    // Flush wins over any same-cycle push or pop.
    assign do_push_s = push & ~full & ~flush_s;
    assign do_pop_s  = pop & not_empty & ~flush_s;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so the heads read zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux_1x2x32_buf.sv
// Buffered 1-to-2 steering stage: each input word goes to out0 or out1 by `check`.
// DEMUX_FLUSH_EN adds a `flush` input that empties both output FIFOs.
module demux_1x2x32_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             check,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
`ifdef DEMUX_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             out1_ready
);

    logic full0_s, full1_s;
    logic sel_full_s;
    logic push0_s, push1_s;
    logic flush_s;

`ifdef DEMUX_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Fullness of the FIFO currently addressed by `check`.
    always_comb begin
        sel_full_s = 1'b1;
        case (check)
            SEL_OUT0: sel_full_s = full0_s;
            SEL_OUT1: sel_full_s = full1_s;
            default:  sel_full_s = 1'b1;
        endcase
    end

    assign in_ready = ~sel_full_s & ~flush_s;
    assign push0_s  = in_valid & in_ready & (check == SEL_OUT0);
    assign push1_s  = in_valid & in_ready & (check == SEL_OUT1);

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0_s),
        .push_data (in_data),
        .full      (full0_s),
        .pop       (out0_ready),
        .head_data (out0_data),
`ifdef DEMUX_FLUSH_EN
        .flush     (flush_s),
`endif
        .not_empty (out0_valid)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1_s),
        .push_data (in_data),
        .full      (full1_s),
        .pop       (out1_ready),
        .head_data (out1_data),
`ifdef DEMUX_FLUSH_EN
        .flush     (flush_s),
`endif
        .not_empty (out1_valid)
    );

endmodule
